// File: rtl/regfile_sched_pkg.sv
// Shared encodings for the register-file scheduler: ops, FSM states, register indices.
package regfile_sched_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_ADD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WR_A = 3'd2,
        S_WR_B = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [4:0] PC   = 5'd0;
    localparam logic [4:0] SP   = 5'd1;
    localparam logic [4:0] LR   = 5'd2;
    localparam logic [4:0] FP   = 5'd3;
    localparam logic [4:0] R4   = 5'd4;
    localparam logic [4:0] R5   = 5'd5;
    localparam logic [4:0] R6   = 5'd6;
    localparam logic [4:0] R7   = 5'd7;
    localparam logic [4:0] R8   = 5'd8;
    localparam logic [4:0] R9   = 5'd9;
    localparam logic [4:0] R10  = 5'd10;
    localparam logic [4:0] R11  = 5'd11;
    localparam logic [4:0] R12  = 5'd12;
    localparam logic [4:0] ADDR = 5'd13;
    localparam int NUM_REGS = 14;

    typedef struct packed {
        op_e         op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [15:0] wd;
    } req_t;

    function automatic logic idx_ok(input logic [4:0] idx);
        return idx < 5'(NUM_REGS);
    endfunction

endpackage

// File: rtl/regfile_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant flag flips only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic last;

    // last==1 means requester 1 won most recently, so requester 0 wins a tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b1;
        else if (update && (gnt != 2'b00))
            last <= gnt[1];
    end
endmodule

// File: rtl/regfile_sched.sv
// Arbitrated two-requester scheduler for READ/WRITE/SWAP/ADD on an external register file.
module regfile_sched
    import regfile_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [4:0]  ra0,
    input  logic [4:0]  ra1,
    input  logic [4:0]  rb0,
    input  logic [4:0]  rb1,
    input  logic [15:0] wd0,
    input  logic [15:0] wd1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    output logic        busy,
    output logic [4:0]  rf_reg1,
    output logic [4:0]  rf_reg2,
    output logic [15:0] rf_data_in,
    output logic        rf_write,
    input  logic [15:0] rf_r1_data,
    input  logic [15:0] rf_r2_data
);
    state_e      state, state_nxt;
    req_t        cur, in0, in1;
    logic        gid, err_q, take, ok;
    logic [1:0]  gnt;
    logic [15:0] tmp_a, tmp_b, din_q;
    logic [4:0]  reg1_q, reg2_q;

    assign in0  = req_t'({op0, ra0, rb0, wd0});
    assign in1  = req_t'({op1, ra1, rb1, wd1});
    assign take = (state == S_IDLE) && (req0 || req1);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1, req0}),
        .update (take),
        .gnt    (gnt)
    );

    // rb only matters for ops that actually read it as a register operand.
    assign ok = idx_ok(cur.ra) &&
                (((cur.op == OP_READ) || (cur.op == OP_SWAP)) ? idx_ok(cur.rb) : 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Address/data ports fall back to their held values outside the active states.
    always_comb begin
        state_nxt  = state;
        rf_write   = 1'b0;
        rf_reg1    = reg1_q;
        rf_reg2    = reg2_q;
        rf_data_in = din_q;
        case (state)
            S_IDLE: if (take) state_nxt = S_EXEC;
            S_EXEC: begin
                rf_reg1 = cur.ra;
                rf_reg2 = cur.rb;
                if (!ok) begin
                    state_nxt = S_DONE;
                end else begin
                    case (cur.op)
                        OP_WRITE: begin
                            rf_write   = 1'b1;
                            rf_data_in = cur.wd;
                            state_nxt  = S_DONE;
                        end
                        OP_READ: state_nxt = S_DONE;
                        default: state_nxt = S_WR_A;
                    endcase
                end
            end
            S_WR_A: begin
                rf_reg1    = cur.ra;
                rf_write   = 1'b1;
                rf_data_in = (cur.op == OP_ADD) ? tmp_a + cur.wd : tmp_b;
                state_nxt  = (cur.op == OP_ADD) ? S_DONE : S_WR_B;
            end
            S_WR_B: begin
                rf_reg1    = cur.rb;
                rf_write   = 1'b1;
                rf_data_in = tmp_a;
                state_nxt  = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign ack0    = (state == S_DONE) && !gid;
    assign ack1    = (state == S_DONE) && gid;
    assign err     = (state == S_DONE) && err_q;
    assign rdata_a = (state == S_DONE) ? tmp_a : 16'h0000;
    assign rdata_b = (state == S_DONE) ? tmp_b : 16'h0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur    <= req_t'('0);
            gid    <= 1'b0;
            err_q  <= 1'b0;
            tmp_a  <= 16'h0000;
            tmp_b  <= 16'h0000;
            reg1_q <= 5'd0;
            reg2_q <= 5'd0;
            din_q  <= 16'h0000;
        end else begin
            reg1_q <= rf_reg1;
            reg2_q <= rf_reg2;
            din_q  <= rf_data_in;
            if (take) begin
                cur   <= gnt[0] ? in0 : in1;
                gid   <= gnt[1];
                err_q <= 1'b0;
            end
            // Rejected ops report zeros rather than whatever sits at a bad index.
            if (state == S_EXEC) begin
                tmp_a <= ok ? rf_r1_data : 16'h0000;
                tmp_b <= ok ? rf_r2_data : 16'h0000;
                err_q <= !ok;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sched.sv
// Directed bench for regfile_sched with a behavioural register file on its rf_* ports.
module tb_regfile_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [4:0]  ra0, ra1, rb0, rb1;
    logic [15:0] wd0, wd1;
    logic        ack0, ack1, err, busy, rf_write;
    logic [15:0] rdata_a, rdata_b, rf_data_in, rf_r1_data, rf_r2_data;
    logic [4:0]  rf_reg1, rf_reg2;

    logic [15:0] mem [0:31];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_total = 0;
    int ack_total = 0;
    logic        res_err;
    logic [15:0] res_a, res_b;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, SW = 2'b10, AD = 2'b11;

    always #5 clk = ~clk;

    regfile_sched dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .ra0(ra0), .ra1(ra1), .rb0(rb0), .rb1(rb1), .wd0(wd0), .wd1(wd1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_data_in(rf_data_in),
        .rf_write(rf_write), .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data)
    );

    assign rf_r1_data = mem[rf_reg1];
    assign rf_r2_data = mem[rf_reg2];

    always @(posedge clk) begin
        if (rf_write) begin
            mem[rf_reg1] <= rf_data_in;
            wr_total <= wr_total + 1;
        end
    end

    always @(negedge clk) if (ack0 || ack1) ack_total <= ack_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int who, input logic [1:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [15:0] d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        @(negedge clk);
        if (who == 0) begin op0 = op; ra0 = a; rb0 = b; wd0 = d; req0 = 1'b1; end
        else          begin op1 = op; ra1 = a; rb1 = b; wd1 = d; req1 = 1'b1; end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((who == 0) ? ack0 : ack1) begin
                got = 1'b1;
                lat = i;
            end
        end
        res_err = err;
        res_a   = rdata_a;
        res_b   = rdata_b;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        int lat, w0, a0;
        int order [4];
        int ng;
        reset = 1'b1;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; ra0 = 0; ra1 = 0; rb0 = 0; rb1 = 0; wd0 = 0; wd1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_we", {31'd0, rf_write}, 32'd0);
        chk("rst_reg1", {27'd0, rf_reg1}, 32'd0);
        chk("rst_rdata", {rdata_a, rdata_b}, 32'd0);
        reset = 1'b0;

        // Tie after reset: requester 0 first, then strict alternation while both hold.
        @(negedge clk);
        op0 = RD; ra0 = 5'd0; rb0 = 5'd0; op1 = RD; ra1 = 5'd0; rb1 = 5'd0;
        req0 = 1'b1; req1 = 1'b1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 || ack1) begin
                order[ng] = ack1 ? 1 : 0;
                ng++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_count", ng, 32'd4);
        if (ng == 4) begin
            chk("rr_g0", order[0], 32'd0);
            chk("rr_g1", order[1], 32'd1);
            chk("rr_g2", order[2], 32'd0);
            chk("rr_g3", order[3], 32'd1);
        end

        run_op(0, WR, 5'd3, 5'd0, 16'h1234, lat);
        chk("wr_lat", lat, 32'd2);
        chk("wr_err", {31'd0, res_err}, 32'd0);
        run_op(0, RD, 5'd3, 5'd3, 16'h0000, lat);
        chk("rd_lat", lat, 32'd2);
        chk("rd_a", {16'd0, res_a}, 32'h1234);
        chk("rd_b", {16'd0, res_b}, 32'h1234);
        chk("rd_err", {31'd0, res_err}, 32'd0);

        run_op(1, WR, 5'd12, 5'd0, 16'hFFFF, lat);
        chk("wr12_lat_r1", lat, 32'd2);
        run_op(1, AD, 5'd12, 5'd0, 16'h0001, lat);
        chk("add_lat", lat, 32'd3);
        chk("add_rdata_a", {16'd0, res_a}, 32'hFFFF);
        chk("add_wrap", {16'd0, mem[12]}, 32'h0000);

        run_op(0, WR, 5'd1, 5'd0, 16'hAAAA, lat);
        run_op(1, WR, 5'd2, 5'd0, 16'h5555, lat);
        run_op(0, SW, 5'd1, 5'd2, 16'h0000, lat);
        chk("swap_lat", lat, 32'd4);
        chk("swap_r1", {16'd0, mem[1]}, 32'h5555);
        chk("swap_r2", {16'd0, mem[2]}, 32'hAAAA);
        chk("swap_rdata_a", {16'd0, res_a}, 32'hAAAA);
        run_op(0, WR, 5'd5, 5'd0, 16'h0F0F, lat);
        run_op(0, SW, 5'd5, 5'd5, 16'h0000, lat);
        chk("swap_same_lat", lat, 32'd4);
        chk("swap_same_r5", {16'd0, mem[5]}, 32'h0F0F);

        w0 = wr_total;
        run_op(0, RD, 5'd0, 5'd14, 16'h0000, lat);
        chk("bad_lat", lat, 32'd2);
        chk("bad_err", {31'd0, res_err}, 32'd1);
        chk("bad_rdata", {res_a, res_b}, 32'd0);
        chk("bad_nowrite", wr_total - w0, 32'd0);

        // Reset landing in the middle of SWAP WR_A.
        run_op(0, WR, 5'd1, 5'd0, 16'h1111, lat);
        run_op(0, WR, 5'd2, 5'd0, 16'h2222, lat);
        @(negedge clk);
        op0 = SW; ra0 = 5'd1; rb0 = 5'd2; wd0 = 16'h0000; req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_wra_we", {31'd0, rf_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_we", {31'd0, rf_write}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_reg1", {27'd0, rf_reg1}, 32'd0);
        req0 = 1'b0;
        a0 = ack_total;
        w0 = wr_total;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_no_ack", ack_total - a0, 32'd0);
        chk("mid_no_write", wr_total - w0, 32'd0);
        chk("mid_r1", {16'd0, mem[1]}, 32'h1111);
        chk("mid_r2", {16'd0, mem[2]}, 32'h2222);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
